// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences core reset, counts run cycles and detects pass/fail/stall/timeout completion
module cpu_run_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES = 2000,
  parameter int STALL_CYCLES = 8,
  parameter logic [WIDTH-1:0] PASS_ADDR = 32'd100,
  parameter logic [WIDTH-1:0] PASS_VALUE = 32'd7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] data_adr,
  input  logic [WIDTH-1:0] write_data,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] stores
);
  typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, STALL, TIMEOUT} state_t;
  state_t state_q, state_d, nxt;
  logic [31:0] hold_q, hold_d, stall_q, stall_d, stall_nx;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic pc_valid_q, pc_valid_d, cpu_reset_q, cpu_reset_d, running_q, running_d, done_q, done_d;
  logic [2:0] status_q, status_d;
  logic [CNT_W-1:0] cycles_q, cycles_d, stores_q, stores_d, cyc_inc, cyc_sat, str_sat;
  logic hit, stall_ev, to_ev;
  // next-state: hold sequencing, run counting and terminal event detection
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    stall_d = stall_q;
    pc_d = pc_q;
    pc_valid_d = pc_valid_q;
    cpu_reset_d = cpu_reset_q;
    running_d = running_q;
    done_d = done_q;
    status_d = status_q;
    cycles_d = cycles_q;
    stores_d = stores_q;
    cyc_inc = cycles_q + CNT_W'(1);
    cyc_sat = &cycles_q ? cycles_q : cyc_inc;
    str_sat = &stores_q ? stores_q : stores_q + CNT_W'(1);
    stall_nx = (pc_valid_q && pc == pc_q) ? stall_q + 32'd1 : 32'd0;
    hit = mem_write && data_adr == PASS_ADDR;
    stall_ev = STALL_CYCLES != 0 && stall_nx == 32'(STALL_CYCLES);
    to_ev = MAX_CYCLES != 0 && cyc_inc == CNT_W'(MAX_CYCLES);
    nxt = hit ? (write_data == PASS_VALUE ? PASS : FAIL) : stall_ev ? STALL : to_ev ? TIMEOUT : RUN;
    case (state_q)
      HOLD: begin
        hold_d = hold_q + 32'd1;
        if (RESET_CYCLES == 0 || hold_d == 32'(RESET_CYCLES)) begin
          state_d = RUN;
          cpu_reset_d = 1'b0;
          running_d = 1'b1;
        end
      end
      RUN: begin
        cycles_d = cyc_sat;
        stores_d = mem_write ? str_sat : stores_q;
        pc_d = pc;
        pc_valid_d = 1'b1;
        stall_d = stall_nx;
        if (nxt != RUN) begin
          state_d = nxt;
          done_d = 1'b1;
          running_d = 1'b0;
          status_d = nxt == PASS ? 3'd1 : nxt == FAIL ? 3'd2 : nxt == STALL ? 3'd3 : 3'd4;
        end
      end
      default: ;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      hold_q <= '0;
      stall_q <= '0;
      pc_q <= '0;
      pc_valid_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q <= 1'b0;
      done_q <= 1'b0;
      status_q <= '0;
      cycles_q <= '0;
      stores_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      stall_q <= stall_d;
      pc_q <= pc_d;
      pc_valid_q <= pc_valid_d;
      cpu_reset_q <= cpu_reset_d;
      running_q <= running_d;
      done_q <= done_d;
      status_q <= status_d;
      cycles_q <= cycles_d;
      stores_q <= stores_d;
    end
  end
  assign cpu_reset = cpu_reset_q;
  assign running = running_q;
  assign done = done_q;
  assign status = status_q;
  assign cycles = cycles_q;
  assign stores = stores_q;
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run-control block for the ARM32 single-cycle CPU: it sequences the core reset, counts run cycles, and detects test completion.
- Completion is any of: pass/fail store, PC stall (branch-to-self) or watchdog timeout.
- Sits beside `top`: drives the core's reset and snoops its `pc`, `mem_write`, `data_adr` and `write_data` buses.
- Replaces fixed-delay reset and fixed-time finish with a parametrised, cycle-accurate, reportable status.

Parameters:
- WIDTH, 32, width of pc/data_adr/write_data.
- CNT_W, 32, width of the cycle and store counters (both saturate).
- RESET_CYCLES, 2, cycles cpu_reset stays high after reset deasserts (0 allowed).
- MAX_CYCLES, 2000, RUN cycles before timeout; 0 disables the watchdog.
- STALL_CYCLES, 8, consecutive unchanged-pc cycles that count as a halt; 0 disables.
- PASS_ADDR, 32'd100, monitored store address.
- PASS_VALUE, 32'd7, value at PASS_ADDR that signals pass.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- pc  input  WIDTH  core program counter.
- mem_write  input  1  core data-memory write enable.
- data_adr  input  WIDTH  core data address.
- write_data  input  WIDTH  core store data.
- cpu_reset  output  1  reset to the core.
- running  output  1  high in RUN.
- done  output  1  high in any terminal state.
- status  output  3  0=HOLD/RUN, 1=PASS, 2=FAIL, 3=STALL, 4=TIMEOUT.
- cycles  output  CNT_W  RUN cycles elapsed.
- stores  output  CNT_W  mem_write cycles seen in RUN.

Behaviour:
- All outputs are registered.
- Reset values while reset=1:
  - state=HOLD, cpu_reset=1, running=0, done=0, status=0, cycles=0, stores=0.
  - Internal hold counter=0, stall counter=0, pc_valid=0.
- FSM states: HOLD, RUN, PASS, FAIL, STALL, TIMEOUT. PASS, FAIL, STALL and TIMEOUT are sticky until reset.
- HOLD:
  - The hold counter increments each edge with reset=0.
  - When it equals RESET_CYCLES, go to RUN; on that edge cpu_reset<=0 and running<=1.
  - With RESET_CYCLES=0, RUN is entered on the first edge after reset deasserts.
- RUN, on every edge:
  - cycles increments, saturating at 2^CNT_W-1.
  - stores increments if mem_write=1, saturating.
- Stall tracking in RUN:
  - pc_q<=pc. Stall counter is zeroed if pc_valid=0 or pc!=pc_q, otherwise incremented.
  - pc_valid<=1 after the first RUN edge.
- Terminal events, evaluated on RUN inputs of the current cycle:
  - Store hit: mem_write=1 and data_adr==PASS_ADDR. Goes to PASS if write_data==PASS_VALUE, else FAIL.
  - Stall: STALL_CYCLES!=0 and the incremented stall count == STALL_CYCLES.
  - Timeout: MAX_CYCLES!=0 and cycles+1 == MAX_CYCLES.
- Event priority when simultaneous: store hit (PASS/FAIL) > STALL > TIMEOUT.
- Terminating edge:
  - cycles and stores still update on this edge.
  - state, status, done<=1 and running<=0 all change on the same edge, so they are visible the cycle after the event.
  - Example: a pass store in the first RUN cycle gives cycles=1.
- Terminal states:
  - cycles, stores and status are frozen.
  - cpu_reset stays 0; the core is not re-reset.
  - Inputs are ignored.
- Reset asserted mid-RUN or in a terminal state: on the next edge all registers return to reset values and the hold sequence restarts.
- Stores to other addresses only increment stores.
- Writes to PASS_ADDR before RUN are ignored, because the core is in reset.

Test Plan:
1. Reset sequencing: reset=1 for 2 cycles then 0, RESET_CYCLES=2 -> cpu_reset high exactly 2 edges after deassert, then 0 with running=1; cycles=0 at RUN entry.
2. Pass: in RUN cycle 5, mem_write=1, data_adr=100, write_data=7; stores at addr 96 in cycles 2 and 3 -> next cycle status=1, done=1, running=0, cycles=5, stores=3, all frozen for 50 more cycles.
3. Fail, and priority over stall: store to 100 with value 9 on the same cycle the stall count reaches 8 -> status=2.
4. Stall: pc=0x10 held constant from RUN cycle 1, STALL_CYCLES=8 -> status=3; cycles=9 (first cycle only seeds pc_q).
5. Timeout: MAX_CYCLES=20, pc incrementing by 4, no stores -> status=4, cycles=20, done=1; with MAX_CYCLES=0 and STALL_CYCLES=0, no termination after 5000 cycles.
6. Reset mid-run: assert reset at RUN cycle 10 for 1 cycle -> outputs return to reset values, cpu_reset re-asserts for RESET_CYCLES, cycles restarts from 0.
